demux16_collect: RTL and testbench
==================================

// Module: demux16_collect
// PURPOSE
//  Receive-side counterpart of the 16:1 strobed select mux. Accepts one data bit per beat,
//  tagged with its select address, and writes it into a WIDTH-bit word at that address.
//  When every position is filled, or on flush, it presents the word and a fill mask
//  downstream through a valid/ready handshake.
//  Sits after the serial mux path and rebuilds the parallel word the mux consumed.
// PARAMETERS
//  WIDTH  16  word width / number of select positions; must equal 2**SEL_W
//  SEL_W  4   select address width
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        input beat present
//  in_ready   out  1        block accepts beats (state COLLECT)
//  in_sel     in   SEL_W    bit position for in_bit
//  in_bit     in   1        data bit
//  in_strobe  in   1        active-high disable; a beat with strobe=1 carries no data and is dropped
//  flush      in   1        force out a partial word (ignored when mask==0)
//  out_valid  out  1        word/mask valid (state HOLD)
//  out_ready  in   1        downstream accepts
//  out_word   out  WIDTH    collected bits; unfilled positions read 0
//  out_mask   out  WIDTH    1 = position written since last hand-off
//  fill_cnt   out  SEL_W+1  popcount of mask, 0..WIDTH
//  dup_err    out  1        one-cycle pulse: accepted beat hit an already-filled position
// BEHAVIOUR
//  Reset: state=COLLECT; word=0, mask=0, fill_cnt=0, dup_err=0, out_valid=0, in_ready=1.
//  Reset mid-word or mid-HOLD discards all contents; no output is produced for them.
//  in_ready = (state==COLLECT); out_valid = (state==HOLD). Both are purely state-decoded.
//  Accept = in_valid & in_ready & ~in_strobe.
//   - Strobed beats leave word, mask and fill_cnt unchanged and raise no error.
//  On accept: word[in_sel] <= in_bit.
//   - If mask[in_sel] was 0: mask[in_sel] <= 1 and fill_cnt increments.
//   - Else: bit is overwritten (last write wins), fill_cnt is unchanged, and dup_err=1
//     the next cycle.
//  COLLECT->HOLD takes effect on the same edge as the write, when either holds:
//   - the post-write mask is all ones; or
//   - flush=1 and the post-write mask is nonzero. The write is applied before the flush.
//  out_valid therefore rises 1 cycle after the completing beat.
//   - A full word takes at least WIDTH accepted beats: WIDTH+1 cycles to out_valid.
//  flush with mask==0 and no accepted beat: no effect. flush in HOLD: ignored.
//  HOLD: word, mask and fill_cnt are frozen; in_ready=0, so beats stall upstream.
//  HOLD->COLLECT on out_valid & out_ready. On the same edge word, mask and fill_cnt clear
//  to 0, so in_ready=1 the next cycle.
//   - out_ready=1 on the first HOLD cycle gives a 1-cycle HOLD; throughput is 1 word per
//     WIDTH+1 cycles.
//  Outputs stay stable while out_valid=1 and out_ready=0, for any number of cycles.
//  in_sel is always in range (WIDTH==2**SEL_W), so there is no out-of-range case.
//  dup_err is registered, high for exactly 1 cycle per duplicate, and 0 when idle.
//  fill_cnt arithmetic is SEL_W+1 bits wide; it reaches WIDTH only at full and never wraps.
// TESTING
//  1 Reset, then 16 beats sel=0..15 with bit=sel[0], out_ready=1 -> out_valid in cycle 17,
//    out_word=16'hAAAA, out_mask=16'hFFFF, fill_cnt=16; in_ready=1 the next cycle.
//  2 Beats sel=3 bit=1 and sel=9 bit=1, then flush -> out_word=16'h0208,
//    out_mask=16'h0208, fill_cnt=2; flush with empty mask -> out_valid stays 0.
//  3 sel=5 bit=1, then sel=5 bit=0 -> dup_err pulses 1 cycle; later commit shows word bit5=0,
//    mask bit5=1, fill_cnt counts the position once.
//  4 Beats with in_strobe=1 interleaved into a full sequence -> no mask change and no dup_err;
//    word completes only after the 16 unstrobed beats.
//  5 Fill the word, hold out_ready=0 for 10 cycles while in_valid=1 -> in_ready=0,
//    out_word/out_mask stable, no beat accepted; release -> next word starts clean.
//  6 Assert rst after 7 accepted beats and again during HOLD -> all outputs at reset values
//    the next cycle; the following 16 beats produce only the new word.

Source files
------------

// File: rtl/demux16_collect.sv
// demux16_collect: rebuilds a parallel word from single-bit beats, each tagged with its bit
// position. A full or flushed word is handed downstream over a valid/ready handshake
// together with a mask of the positions that were written.
module demux16_collect #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SEL_W-1:0] in_sel_i,
  input  logic             in_bit_i,
  input  logic             in_strobe_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_word_o,
  output logic [WIDTH-1:0] out_mask_o,
  output logic [SEL_W:0]   fill_cnt_o,
  output logic             dup_err_o
);

  typedef enum logic {StCollect, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [SEL_W:0]   cnt_q, cnt_d;
  logic             dup_q, dup_d;
  logic             accept;

  // Strobed beats carry no data and are treated as if no beat were present.
  assign accept = in_valid_i & (state_q == StCollect) & ~in_strobe_i;

  // Next-state: write the accepted bit first, then decide whether the word is handed off.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    dup_d   = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          word_d[in_sel_i] = in_bit_i;
          if (mask_q[in_sel_i]) begin
            dup_d = 1'b1;
          end else begin
            mask_d[in_sel_i] = 1'b1;
            cnt_d            = cnt_q + {{SEL_W{1'b0}}, 1'b1};
          end
        end
        // Flush only ever releases a non-empty word, and sees the beat on the same edge.
        if ((&mask_d) || (flush_i && (|mask_d))) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          state_d = StCollect;
          word_d  = '0;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StCollect;
      word_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
    end
  end

  assign in_ready_o  = (state_q == StCollect);
  assign out_valid_o = (state_q == StHold);
  assign out_word_o  = word_q;
  assign out_mask_o  = mask_q;
  assign fill_cnt_o  = cnt_q;
  assign dup_err_o   = dup_q;

endmodule

// File: tb/tb_demux16_collect.sv
// Bench for demux16_collect: a word/mask model checked against the DUT on every cycle,
// plus literal expectations for each directed scenario.
module tb_demux16_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic        in_bit;
  logic        in_strobe;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [15:0] out_mask;
  logic [4:0]  fill_cnt;
  logic        dup_err;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state: collected bits, written positions, hand-off pending, duplicate seen.
  logic [15:0] m_word = '0;
  logic [15:0] m_mask = '0;
  bit          m_hold = 1'b0;
  bit          m_dup  = 1'b0;

  demux16_collect #(.WIDTH(16), .SEL_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_sel_i    (in_sel),
    .in_bit_i    (in_bit),
    .in_strobe_i (in_strobe),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_word_o  (out_word),
    .out_mask_o  (out_mask),
    .fill_cnt_o  (fill_cnt),
    .dup_err_o   (dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs present at each rising edge.
  always @(posedge clk) begin
    logic [15:0] w, m;
    bit          h, d;
    w = m_word; m = m_mask; h = m_hold; d = 1'b0;
    if (rst) begin
      w = '0; m = '0; h = 1'b0;
    end else if (!h) begin
      if (in_valid && !in_strobe) begin
        d = m[in_sel];
        w[in_sel] = in_bit;
        m[in_sel] = 1'b1;
      end
      if (m == 16'hFFFF || (flush && m != 16'h0000)) h = 1'b1;
    end else if (out_ready) begin
      w = '0; m = '0; h = 1'b0;
    end
    m_word <= w;
    m_mask <= m;
    m_hold <= h;
    m_dup  <= d;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(!m_hold));
      check("out_valid", 32'(out_valid), 32'(m_hold));
      check("out_word",  32'(out_word),  32'(m_word));
      check("out_mask",  32'(out_mask),  32'(m_mask));
      check("fill_cnt",  32'(fill_cnt),  32'($countones(m_mask)));
      check("dup_err",   32'(dup_err),   32'(m_dup));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] sel, input logic b, input logic strobe);
    in_valid = 1'b1; in_sel = sel; in_bit = b; in_strobe = strobe; flush = 1'b0;
    step();
    in_valid = 1'b0; in_strobe = 1'b0;
  endtask

  task automatic idle(input logic f);
    in_valid = 1'b0; flush = f;
    step();
    flush = 1'b0;
  endtask

  task automatic check_reset(input string name);
    check({name, "_ready"}, 32'(in_ready),  32'd1);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_word"},  32'(out_word),  32'd0);
    check({name, "_mask"},  32'(out_mask),  32'd0);
    check({name, "_fill"},  32'(fill_cnt),  32'd0);
    check({name, "_dup"},   32'(dup_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] s;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_bit = 1'b0; in_strobe = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    check_reset("reset");

    // 1: full word, 16 beats, bit = sel[0]
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      if (i == 15) check("t1_not_yet", 32'(out_valid), 32'd0);
      beat(s, s[0], 1'b0);
    end
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_word",  32'(out_word),  32'h0000AAAA);
    check("t1_mask",  32'(out_mask),  32'h0000FFFF);
    check("t1_fill",  32'(fill_cnt),  32'd16);
    idle(1'b0);
    check("t1_ready_after", 32'(in_ready), 32'd1);
    check("t1_clear_mask",  32'(out_mask), 32'd0);

    // 2: partial word by flush; then flush on empty mask
    out_ready = 1'b0;
    beat(4'd3, 1'b1, 1'b0);
    beat(4'd9, 1'b1, 1'b0);
    idle(1'b1);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_word",  32'(out_word),  32'h00000208);
    check("t2_mask",  32'(out_mask),  32'h00000208);
    check("t2_fill",  32'(fill_cnt),  32'd2);
    out_ready = 1'b1; idle(1'b0); out_ready = 1'b0;
    idle(1'b1);
    check("t2_empty_flush", 32'(out_valid), 32'd0);
    idle(1'b0);

    // 3: duplicate position, last write wins
    beat(4'd5, 1'b1, 1'b0);
    check("t3_no_dup", 32'(dup_err), 32'd0);
    beat(4'd5, 1'b0, 1'b0);
    check("t3_dup", 32'(dup_err), 32'd1);
    idle(1'b0);
    check("t3_dup_gone", 32'(dup_err), 32'd0);
    idle(1'b1);
    check("t3_word", 32'(out_word), 32'd0);
    check("t3_mask", 32'(out_mask), 32'h00000020);
    check("t3_fill", 32'(fill_cnt), 32'd1);
    out_ready = 1'b1; idle(1'b0);

    // 4: strobed beats interleaved; bit = sel[1]
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      beat(4'(i + 1), 1'b1, 1'b1);
      check("t4_strobe_nodup", 32'(dup_err), 32'd0);
      if (i == 15) begin
        check("t4_fill15",   32'(fill_cnt),  32'd15);
        check("t4_not_full", 32'(out_valid), 32'd0);
      end
      beat(s, s[1], 1'b0);
    end
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_word",  32'(out_word),  32'h0000CCCC);
    idle(1'b0);

    // 5: back-pressure for 10 cycles with beats pending
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(4'(i), 1'b1, 1'b0);
    in_valid = 1'b1; in_sel = 4'd0; in_bit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_stall_ready", 32'(in_ready), 32'd0);
      check("t5_stall_word",  32'(out_word), 32'h0000FFFF);
    end
    in_valid = 1'b0;
    out_ready = 1'b1; idle(1'b0);
    check("t5_clean_mask", 32'(out_mask), 32'd0);
    check("t5_clean_word", 32'(out_word), 32'd0);

    // 6: reset mid-word and mid-hold
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) beat(4'(i), 1'b1, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check_reset("t6_mid");
    for (int i = 0; i < 16; i++) beat(4'(i), 1'b1, 1'b0);
    check("t6_hold", 32'(out_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check_reset("t6_hold");
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      beat(s, ~s[0], 1'b0);
    end
    check("t6_word", 32'(out_word), 32'h00005555);
    check("t6_mask", 32'(out_mask), 32'h0000FFFF);
    out_ready = 1'b1; idle(1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
